arms_sequencer: RTL
===================

Name: arms_sequencer

Overview:
- Clocked controller that programs and runs one ARMS counter on behalf of two requesters.
- Each requester posts a counting job (direction, 4-bit limit). Jobs are arbitrated round-robin.
- For the granted job the block drives the counter's strobe/command/data interface (clear, load limit, start) and watches COUT until it reaches the limit or a timeout expires.
- It then reports completion to the owning requester. It sits between the host-side job logic and the counter instance, and is the only driver of STRB/CON/DATA.

Parameters:
- STRB_HI, 2, cycles STRB is held high per command (>=1).
- STRB_LO, 2, cycles STRB is held low after each high phase (>=1).
- TIMEOUT, 64, max cycles spent in WAIT before the job is aborted with error (>=17).

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- REQ0  input  1  requester 0 job request, level
- DIR0  input  1  requester 0 direction: 0 = up (CON 10), 1 = down (CON 11)
- LIM0  input  4  requester 0 count limit
- REQ1  input  1  requester 1 job request, level
- DIR1  input  1  requester 1 direction
- LIM1  input  4  requester 1 count limit
- COUT  input  4  counter value returned from the counter
- STRB  output  1  strobe to counter; posedge latches CON, negedge loads DATA
- CON  output  2  counter command: 00 clear, 01 load limit, 10 count up, 11 count down
- DATA  output  4  limit value to counter
- BUSY  output  1  high from grant until the DONE cycle inclusive
- OWNER  output  1  index of the current or most recent grantee
- DONE  output  2  one-hot, one-cycle completion pulse per requester
- ERR  output  1  valid with DONE; 1 = timeout abort

Behaviour:
- All outputs are registered.
- Reset (async) values: STRB=0, CON=00, DATA=0, BUSY=0, OWNER=1, DONE=00, ERR=0, FSM=IDLE, step=CLR, counters=0.
- FSM states: IDLE, SU, HI, LO, WAIT, FIN.
- IDLE: if any REQ is high, grant at the next edge.
  - Round-robin: the requester not equal to OWNER wins a tie. After reset OWNER=1, so REQ0 wins the first tie.
  - At grant: capture DIR/LIM of the winner into dir_q/lim_q, set OWNER, set BUSY=1, step=CLR, go to SU.
  - Later changes to DIR/LIM have no effect on the running job.
- Command steps run in the order CLR (CON=00, DATA=0), LDL (CON=01, DATA=lim_q), RUN (CON={1,dir_q}, DATA=lim_q).
- Each step passes through three states:
  - SU: exactly 1 cycle. CON/DATA driven to the step value, STRB=0. This gives setup before the strobe edge.
  - HI: STRB=1 for STRB_HI cycles. CON/DATA stable.
  - LO: STRB=0 for STRB_LO cycles. CON/DATA still stable, which covers the negedge limit load.
  - After LO of CLR go to SU of LDL. After LO of LDL go to SU of RUN. After LO of RUN go to WAIT.
- With default parameters, grant to WAIT entry is 15 cycles.
- CON/DATA keep their last value from RUN through WAIT and FIN. They return to 00/0 only on reset.
- WAIT: a cycle counter starts at 0 on entry.
  - If COUT==lim_q in a cycle, go to FIN with err=0. This includes the first WAIT cycle, so limit 0 completes immediately.
  - Else if the counter reaches TIMEOUT-1, go to FIN with err=1.
  - Match takes priority over timeout in the same cycle.
- FIN: exactly 1 cycle.
  - DONE[OWNER]=1 and ERR=err. BUSY is still 1 in this cycle.
  - Next cycle: BUSY=0, DONE=00, ERR=0, state IDLE.
  - A new grant occurs no earlier than the cycle after FIN. There is always one IDLE cycle between jobs, so the requester may drop REQ on seeing DONE.
- Requester contract: REQn stays high until DONE[n]. Deasserting REQ mid-job is ignored; the job runs to completion.
- Expected WAIT latency: up count reaches lim_q in lim_q CLK cycles; down count from 0 takes 16-lim_q cycles (wrap 0→15). Both are within the default TIMEOUT.
- Reset mid-operation: the job is dropped with no DONE pulse. STRB drops to 0 immediately; an outstanding strobe negedge is tolerated.
- Simultaneous REQ0 and REQ1 in IDLE: only one is granted. The other is served next if it is still requesting.
- No ERR pulse without DONE. DONE is never 11.

Test Plan:
- Reset, REQ0=1, DIR0=0, LIM0=5:
  - CON sequence 00→01→10, STRB high 2 cycles per step, DATA=5 during LDL.
  - BUSY rises at grant; WAIT entered 15 cycles after grant.
  - DONE=01, ERR=0 once COUT=5.
- REQ1=1, DIR1=1, LIM1=12:
  - Counter wraps 0→15→...→12 in 4 cycles.
  - DONE=10, ERR=0, CON held 11.
- REQ0 and REQ1 asserted in the same cycle twice in a row (both held):
  - Grants go 0,1,0,1 with OWNER toggling.
  - Each DONE is followed by exactly one IDLE cycle.
- LIM0=0, up: DONE=01, ERR=0 on the first WAIT cycle, with no counting.
- Counter model stuck (COUT held at 0), LIM0=3: after 64 WAIT cycles, DONE=01 and ERR=1, then BUSY=0.
- RST asserted during the HI phase of LDL:
  - STRB=0, CON=00, BUSY=0 immediately, no DONE.
  - After release, with REQ0 still high, the job restarts from CLR.

Source files
------------

// File: rtl/arms_sequencer_if.sv
// Bundle between the ARMS sequencer, its two requesters and the counter.
//
// Handshake: REQn is a level request that the requester holds until it sees
// its one-cycle DONE[n] pulse; the sequencer grants only from IDLE, BUSY is
// high from the grant through the DONE cycle inclusive, ERR is meaningful
// only while DONE is non-zero, and STRB/CON/DATA are driven solely by the
// sequencer.
interface arms_sequencer_if;
  logic       REQ0;
  logic       DIR0;
  logic [3:0] LIM0;
  logic       REQ1;
  logic       DIR1;
  logic [3:0] LIM1;
  logic [3:0] COUT;
  logic       STRB;
  logic [1:0] CON;
  logic [3:0] DATA;
  logic       BUSY;
  logic       OWNER;
  logic [1:0] DONE;
  logic       ERR;
  logic [2:0] DBG_STATE;

  // Sequencer side
  modport master (
    input  REQ0, DIR0, LIM0, REQ1, DIR1, LIM1, COUT,
    output STRB, CON, DATA, BUSY, OWNER, DONE, ERR, DBG_STATE
  );

  // Requester / counter side
  modport slave (
    output REQ0, DIR0, LIM0, REQ1, DIR1, LIM1, COUT,
    input  STRB, CON, DATA, BUSY, OWNER, DONE, ERR, DBG_STATE
  );
endinterface

// File: rtl/arms_sequencer.sv
// ARMS counter sequencer: round-robin arbitration between two requesters,
// then clear / load-limit / run command strobes, then wait for COUT to hit
// the limit (or time out) and pulse DONE to the owner.
module arms_sequencer #(
  parameter int STRB_HI = 2,
  parameter int STRB_LO = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST,
  arms_sequencer_if.master bus
);

  localparam int MAX_HL = (STRB_HI > STRB_LO) ? STRB_HI : STRB_LO;
  localparam int MAXC   = (TIMEOUT > MAX_HL) ? TIMEOUT : MAX_HL;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HI_LAST   = CW'(STRB_HI - 1);
  localparam logic [CW-1:0] LO_LAST   = CW'(STRB_LO - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SU   = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_WAIT = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ST_CLR = 2'd0,
    ST_LDL = 2'd1,
    ST_RUN = 2'd2
  } step_t;

  state_t        state_q, state_d;
  step_t         step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [3:0]    lim_q, lim_d;
  logic          owner_q, owner_d;
  logic          fin_err_q, fin_err_d;

  logic          strb_q, strb_d;
  logic [1:0]    con_q, con_d;
  logic [3:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic [1:0]    done_q, done_d;
  logic          err_q, err_d;

  logic          win;

  // Round-robin winner: on a tie the requester that is not the last owner wins
  assign win = (bus.REQ0 && bus.REQ1) ? ~owner_q : bus.REQ1;

  // State and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      step_q    <= ST_CLR;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      lim_q     <= 4'd0;
      owner_q   <= 1'b1;
      fin_err_q <= 1'b0;
      strb_q    <= 1'b0;
      con_q     <= 2'b00;
      data_q    <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      lim_q     <= lim_d;
      owner_q   <= owner_d;
      fin_err_q <= fin_err_d;
      strb_q    <= strb_d;
      con_q     <= con_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next state: grant, SU/HI/LO per command step, then WAIT for match or timeout
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    lim_d     = lim_q;
    owner_d   = owner_q;
    fin_err_d = fin_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          owner_d = win;
          dir_d   = win ? bus.DIR1 : bus.DIR0;
          lim_d   = win ? bus.LIM1 : bus.LIM0;
          step_d  = ST_CLR;
          cnt_d   = '0;
          state_d = S_SU;
        end
      end
      S_SU: begin
        cnt_d   = '0;
        state_d = S_HI;
      end
      S_HI: begin
        if (cnt_q == HI_LAST) begin
          cnt_d   = '0;
          state_d = S_LO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LO: begin
        if (cnt_q == LO_LAST) begin
          cnt_d = '0;
          unique case (step_q)
            ST_CLR: begin
              step_d  = ST_LDL;
              state_d = S_SU;
            end
            ST_LDL: begin
              step_d  = ST_RUN;
              state_d = S_SU;
            end
            default: state_d = S_WAIT;
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        // A match wins over a timeout landing in the same cycle
        if (bus.COUT == lim_q) begin
          fin_err_d = 1'b0;
          state_d   = S_FIN;
        end else if (cnt_q == WAIT_LAST) begin
          fin_err_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so that every output is a register
  always_comb begin
    strb_d = (state_d == S_HI);
    con_d  = con_q;
    data_d = data_q;
    if (state_d == S_SU) begin
      unique case (step_d)
        ST_CLR: begin
          con_d  = 2'b00;
          data_d = 4'd0;
        end
        ST_LDL: begin
          con_d  = 2'b01;
          data_d = lim_d;
        end
        default: begin
          con_d  = {1'b1, dir_d};
          data_d = lim_d;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
    done_d = 2'b00;
    if (state_d == S_FIN) begin
      done_d = owner_d ? 2'b10 : 2'b01;
    end
    err_d = (state_d == S_FIN) && fin_err_d;
  end

  assign bus.STRB      = strb_q;
  assign bus.CON       = con_q;
  assign bus.DATA      = data_q;
  assign bus.BUSY      = busy_q;
  assign bus.OWNER     = owner_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;
  assign bus.DBG_STATE = state_q;

endmodule
